// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder onto a word-organised SRAM with byte-lane writes, programmable wait states and read-after-write forwarding.
// Optional ERROR responses for bad/misaligned accesses are enabled by defining AHB_SRAM_ERR_EN.
module ahb_sram_slave #(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [IW-1:0]   idx_q;
    logic [3:0]      lanes_q;
    logic            write_q;
    logic            wr_pend;
    logic [31:0]     mem [MEM_WORDS];

    logic [31:0]     offset;
    logic [IW-1:0]   haddr_idx;
    logic [3:0]      lanes_in;
    logic            bad;
    logic            can_accept, accept, commit;
    logic            rd_load;
    logic [IW-1:0]   rd_idx;
    logic [31:0]     mem_rd, rd_word;
    logic            unused_ok;

    assign offset    = HADDR - BASE_ADDR;
    assign haddr_idx = offset[IW+1:2];
    assign unused_ok = ^{HBURST, HTRANS[0], offset[31:IW+2], offset[1:0]};

    always_comb begin
        case (HSIZE)
            3'd0:    lanes_in = 4'b0001 << HADDR[1:0];
            3'd1:    lanes_in = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes_in = 4'b1111;
        endcase
    end

`ifdef AHB_SRAM_ERR_EN
    assign bad = (|offset[31:IW+2]) | (HSIZE > 3'd2) |
                 ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (|HADDR[1:0]));
`else
    assign bad = 1'b0;
`endif

    assign can_accept = (state == S_IDLE) | (state == S_DATA) | (state == S_ERR2);
    assign accept     = can_accept & HSEL & HREADYIN & HTRANS[1];
    assign commit     = (state == S_DATA) & HREADYIN & wr_pend;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // WAIT and ERR1 are stalls we drive ourselves, so they advance even though HREADYIN is low.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (HREADYIN) begin
                    if (accept)
                        state_nxt = bad ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
                    else
                        state_nxt = S_IDLE;
                end
            end
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_DATA;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            S_WAIT: HREADYOUT = 1'b0;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt     <= 4'd0;
            idx_q   <= '0;
            lanes_q <= 4'd0;
            write_q <= 1'b0;
            wr_pend <= 1'b0;
        end else begin
            if (commit) wr_pend <= 1'b0;
            if (accept) begin
                idx_q   <= haddr_idx;
                lanes_q <= lanes_in;
                write_q <= HWRITE;
                wr_pend <= HWRITE & ~bad;
                cnt     <= WS_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Reads enter DATA either straight from the bus (no wait states) or at the end of WAIT.
    assign rd_load = (accept & ~HWRITE & ~bad & (WAIT_STATES == 0)) |
                     ((state == S_WAIT) & (cnt == 4'd0) & ~write_q);
    assign rd_idx  = (state == S_WAIT) ? idx_q : haddr_idx;
    assign mem_rd  = mem[rd_idx];

    always_comb begin
        rd_word = mem_rd;
        for (int i = 0; i < 4; i++) begin
            if (commit && idx_q == rd_idx && lanes_q[i])
                rd_word[i*8 +: 8] = HWDATA[i*8 +: 8];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     HRDATA <= 32'd0;
        else if (rd_load) HRDATA <= rd_word;
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) mem[idx_q][i*8 +: 8] <= HWDATA[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two slaves (0 and 2 wait states) behind a small AHB-Lite interconnect model; a scoreboard checks each data phase.
module tb_ahb_sram_slave;
    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        ro0, ro2, resp0, resp2;
    logic [31:0] rd0, rd2;
    logic        tgt, dp_owner, dp_valid;
    logic [31:0] pend;
    logic        hresp;
    logic [31:0] hrdata;

    int total = 0;
    int passed = 0;
    int lowc = 0;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        logic        resp;
        int          waits;
        string       name;
    } exp_t;
    exp_t expq[$];

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYIN(hready), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0));

    ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut2 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYIN(hready), .HREADYOUT(ro2), .HRESP(resp2), .HRDATA(rd2));

    assign hready = dp_owner ? ro2 : ro0;
    assign hresp  = dp_owner ? resp2 : resp0;
    assign hrdata = dp_owner ? rd2 : rd0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_owner <= 1'b0;
            dp_valid <= 1'b0;
        end else if (hready) begin
            dp_owner <= tgt;
            dp_valid <= (htrans != 2'b00);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && dp_valid) begin
                if (!hready) begin
                    lowc++;
                    if (expq.size() > 0) check({expq[0].name, "_stall_resp"}, 32'(hresp), 32'(expq[0].resp));
                end else begin
                    if (expq.size() == 0) begin
                        total++;
                        $display("FAIL dp_unexpected: data phase completed with no expected entry");
                    end else begin
                        e = expq.pop_front();
                        check({e.name, "_waits"}, 32'(lowc), 32'(e.waits));
                        check({e.name, "_resp"}, 32'(hresp), 32'(e.resp));
                        if (e.chk) check({e.name, "_rdata"}, hrdata, e.data);
                    end
                    lowc = 0;
                end
            end else begin
                lowc = 0;
            end
        end
    end

    task automatic ahb(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic t,
                       input logic push, input logic chk, input logic [31:0] ed,
                       input logic er, input int ew, input string nm);
        exp_t e;
        int   n;
        logic r;
        tgt    = t;
        hsel0  = ~t;
        hsel2  = t;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hburst = 3'b001;
        hwdata = pend;
        if (push && tr != 2'b00) begin
            e.chk = chk; e.data = ed; e.resp = er; e.waits = ew; e.name = nm;
            expq.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            r = hready;
            @(posedge clk);
            n++;
        end while (!r && n < 64);
        if (!r) begin
            $display("FAIL %s_timeout: hready stuck at %b, required 1", nm, r);
            $fatal(1, "bus hang");
        end
        #1;
        pend = wd;
    endtask

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;

    task automatic idle(input logic t);
        ahb(IDL, 1'b0, 3'd2, 32'h0, 32'h0, t, 1'b0, 1'b0, 32'h0, 1'b0, 0, "idle");
    endtask

    initial begin
        rstn = 1'b0; tgt = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; haddr = 32'h0;
        htrans = IDL; hwrite = 1'b0; hsize = 3'd2; hburst = 3'b000; hwdata = 32'h0; pend = 32'h0;
        #3;
        check("rst_hreadyout0", 32'(ro0), 32'd1);
        check("rst_hresp0", 32'(resp0), 32'd0);
        check("rst_hrdata0", rd0, 32'd0);
        check("rst_hreadyout2", 32'(ro2), 32'd1);
        check("rst_hresp2", 32'(resp2), 32'd0);
        check("rst_hrdata2", rd2, 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back write then read of the same word: forwarding path.
        ahb(NSQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, "fwd_wr");
        ahb(NSQ, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 0, "fwd_rd");
        idle(1'b0);

        // Two wait states.
        ahb(NSQ, 1'b1, 3'd2, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2, "ws_wr");
        ahb(NSQ, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 2, "ws_rd");
        idle(1'b1);

        // Byte and halfword lanes, with the last write forwarded into the read.
        ahb(NSQ, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, "ln_wr");
        ahb(NSQ, 1'b1, 3'd0, 32'h21, 32'h0000AA00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, "ln_byte");
        ahb(NSQ, 1'b1, 3'd1, 32'h22, 32'hBBCC0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, "ln_half");
        ahb(NSQ, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 32'hBBCCAA44, 1'b0, 0, "ln_rd_fwd");
        idle(1'b0);
        ahb(NSQ, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 32'hBBCCAA44, 1'b0, 0, "ln_rd_mem");
        ahb(NSQ, 1'b0, 3'd0, 32'h23, 32'h0, 1'b0, 1'b1, 1'b1, 32'hBBCCAA44, 1'b0, 0, "ln_rd_byte");
        idle(1'b0);

        // INCR burst with a BUSY cycle on the wait-state slave.
        ahb(NSQ, 1'b1, 3'd2, 32'h40, 32'd1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2, "bu_w0");
        ahb(SQ,  1'b1, 3'd2, 32'h44, 32'd2, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2, "bu_w1");
        ahb(BSY, 1'b1, 3'd2, 32'h48, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0, "bu_busy");
        ahb(SQ,  1'b1, 3'd2, 32'h48, 32'd3, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2, "bu_w2");
        ahb(SQ,  1'b1, 3'd2, 32'h4C, 32'd4, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2, "bu_w3");
        for (int i = 0; i < 4; i++)
            ahb(i == 0 ? NSQ : SQ, 1'b0, 3'd2, 32'h40 + 32'(4 * i), 32'h0, 1'b1, 1'b1, 1'b1,
                32'(i + 1), 1'b0, 2, "bu_rd");
        idle(1'b1);

`ifdef AHB_SRAM_ERR_EN
        ahb(NSQ, 1'b1, 3'd2, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, "er_wr0");
        ahb(NSQ, 1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1, "er_oor");
        ahb(NSQ, 1'b0, 3'd2, 32'h02, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1, "er_misal");
        ahb(NSQ, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, 0, "er_rd0");
        idle(1'b0);
`endif

        // Reset asserted while a write is stalled in WAIT.
        ahb(NSQ, 1'b1, 3'd2, 32'h30, 32'h55AA55AA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2, "rs_pre");
        idle(1'b1);
        ahb(NSQ, 1'b1, 3'd2, 32'h30, 32'hFFFF0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, "rs_wr");
        htrans = IDL;
        hwdata = pend;
        @(negedge clk);
        #2;
        check("rs_in_wait", 32'(ro2), 32'd0);
        rstn = 1'b0;
        #1;
        check("rs_async_hreadyout", 32'(ro2), 32'd1);
        check("rs_async_hresp", 32'(resp2), 32'd0);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        rstn = 1'b1;
        ahb(NSQ, 1'b0, 3'd2, 32'h30, 32'h0, 1'b1, 1'b1, 1'b1, 32'h55AA55AA, 1'b0, 2, "rs_rd");
        idle(1'b1);
        idle(1'b1);

        repeat (4) @(posedge clk);
        check("scoreboard_drain", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
